// File: rtl/qix_pkg.sv
// qix_pkg: shared types and constants for the Qix Data/Video shared-RAM arbiter
package qix_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_D,
        SERVE_V,
        RESP_D,
        RESP_V
    } arb_state_t;

    localparam logic MBOX_SET_OFS  = 1'b0;
    localparam logic MBOX_ACK_OFS  = 1'b1;
    localparam int   SHARED_RAM_AW = 10;

endpackage

// File: rtl/qix_spram.sv
// qix_spram: synchronous single-port 8-bit RAM, read-before-write, BRAM-inferable
module qix_spram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    din,
    output logic [7:0]    q
);

    logic [7:0] mem [2**AW];

    // q always returns the old contents, even on the cycle a write lands
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        q <= mem[addr];
    end

endmodule

// File: rtl/qix_shared_ram_arbiter.sv
// qix_shared_ram_arbiter: serialises Data/Video CPU access to shared RAM and runs the FIRQ mailbox
module qix_shared_ram_arbiter
    import qix_pkg::*;
#(
    parameter int         RAM_AW     = SHARED_RAM_AW,
    parameter logic [7:0] MBOX_RDATA = 8'hFF
) (
    input  logic        clk_20m,
    input  logic        reset_n,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [10:0] d_addr,
    input  logic [7:0]  d_din,
    output logic [7:0]  d_dout,
    output logic        d_ack,
    input  logic        v_req,
    input  logic        v_we,
    input  logic [10:0] v_addr,
    input  logic [7:0]  v_din,
    output logic [7:0]  v_dout,
    output logic        v_ack,
    output logic        d_firq_n,
    output logic        v_firq_n
);

    arb_state_t  state_q, state_d;
    logic        last_v_q, last_v_d;
    logic        mbox_q, mbox_d;
    logic [7:0]  d_hold_q, d_hold_d, v_hold_q, v_hold_d;
    logic        d_firq_n_q, d_firq_n_d, v_firq_n_q, v_firq_n_d;
    logic        serve_d, serve_v, s_we;
    logic [10:0] s_addr;
    logic [7:0]  s_din, ram_q, rd_data;

    assign serve_d = state_q == SERVE_D;
    assign serve_v = state_q == SERVE_V;
    assign s_addr  = serve_v ? v_addr : d_addr;
    assign s_din   = serve_v ? v_din : d_din;
    assign s_we    = ((serve_d & d_we) | (serve_v & v_we)) & ~s_addr[10];

    qix_spram #(.AW(RAM_AW)) u_ram (
        .clk  (clk_20m),
        .we   (s_we),
        .addr (s_addr[RAM_AW-1:0]),
        .din  (s_din),
        .q    (ram_q)
    );

    // Fresh read data is shown during the ack cycle, then held until the next ack
    assign rd_data  = mbox_q ? MBOX_RDATA : ram_q;
    assign d_ack    = state_q == RESP_D;
    assign v_ack    = state_q == RESP_V;
    assign d_dout   = d_ack ? rd_data : d_hold_q;
    assign v_dout   = v_ack ? rd_data : v_hold_q;
    assign d_firq_n = d_firq_n_q;
    assign v_firq_n = v_firq_n_q;

    // Next-state: round-robin grant on ties, mailbox side-effects in SERVE, data capture in RESP
    always_comb begin
        state_d    = state_q;
        last_v_d   = last_v_q;
        mbox_d     = mbox_q;
        d_hold_d   = d_hold_q;
        v_hold_d   = v_hold_q;
        d_firq_n_d = d_firq_n_q;
        v_firq_n_d = v_firq_n_q;
        case (state_q)
            IDLE: begin
                if (d_req && (!v_req || last_v_q)) state_d = SERVE_D;
                else if (v_req) state_d = SERVE_V;
            end
            SERVE_D: begin
                last_v_d = 1'b0;
                mbox_d   = d_addr[10];
                state_d  = RESP_D;
                if (d_addr[10] && d_addr[0] == MBOX_SET_OFS && d_we) v_firq_n_d = 1'b0;
                if (d_addr[10] && d_addr[0] == MBOX_ACK_OFS) d_firq_n_d = 1'b1;
            end
            SERVE_V: begin
                last_v_d = 1'b1;
                mbox_d   = v_addr[10];
                state_d  = RESP_V;
                if (v_addr[10] && v_addr[0] == MBOX_SET_OFS && v_we) d_firq_n_d = 1'b0;
                if (v_addr[10] && v_addr[0] == MBOX_ACK_OFS) v_firq_n_d = 1'b1;
            end
            RESP_D: begin
                d_hold_d = rd_data;
                state_d  = IDLE;
            end
            RESP_V: begin
                v_hold_d = rd_data;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset leaves Video as last grant so Data wins the first tie
    always_ff @(posedge clk_20m or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_v_q   <= 1'b1;
            mbox_q     <= 1'b0;
            d_hold_q   <= 8'h00;
            v_hold_q   <= 8'h00;
            d_firq_n_q <= 1'b1;
            v_firq_n_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_v_q   <= last_v_d;
            mbox_q     <= mbox_d;
            d_hold_q   <= d_hold_d;
            v_hold_q   <= v_hold_d;
            d_firq_n_q <= d_firq_n_d;
            v_firq_n_q <= v_firq_n_d;
        end
    end

endmodule
